// File: rtl/txn_pkg.sv
// ---------------------------------------------------------------------------
// txn_pkg
// Shared definitions for the transaction sequencer:
//   state_e        - sequencer FSM state encodings
//   reject_cause_e - reason a transaction was refused in CHECK
//   cnt_width()    - width of a counter that must hold 0..n
// ---------------------------------------------------------------------------
package txn_pkg;

    typedef enum logic [3:0] {
        INIT1       = 4'd0,
        INIT2       = 4'd1,
        IDLE        = 4'd2,
        GET_SRC     = 4'd3,
        GET_DST     = 4'd4,
        GET_AMT     = 4'd5,
        GET_KEY     = 4'd6,
        ARMED       = 4'd7,
        CHECK       = 4'd8,
        TRANSACTION = 4'd9,
        CLEANUP     = 4'd10
    } state_e;

    typedef enum logic [2:0] {
        RC_NONE     = 3'd0,
        RC_SAME_IDX = 3'd1,
        RC_ZERO_AMT = 3'd2,
        RC_BAD_IDX  = 3'd3,
        RC_OVERDRAW = 3'd4
    } reject_cause_e;

    // Smallest width able to count 0..n; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/edge_detect.sv
// ---------------------------------------------------------------------------
// edge_detect
// Rising-edge detector for a synchronous button level. o_rise is high in the
// cycle where i_sig is 1 and was 0 in the previous cycle, so holding the
// input high yields a single event.
//   clk    in  clock
//   rst_n  in  async active-low reset (clears the history register)
//   i_sig  in  level to watch
//   o_rise out one-cycle rising-edge indication
// ---------------------------------------------------------------------------
module edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic i_sig,
    output logic o_rise
);

    logic r_prev;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= i_sig;
        end
    end

    assign o_rise = i_sig & ~r_prev;

endmodule

// File: rtl/txn_sequencer.sv
// ---------------------------------------------------------------------------
// txn_sequencer
// Control FSM for a player-to-player balance transfer: seed warm-up, memory
// init, four load-button captures (source, destination, amount, key), a
// start button, a one-cycle legality check, the transfer itself guarded by
// a watchdog, and a one-cycle datapath clear.
//
// Ports (PW = clog2(NUM_PLAYERS)):
//   clock, resetn                    clock / async active-low reset
//   load_signal, start_signal        user buttons (active high)
//   data_in[AMT_W]                   switch value captured on load
//   finished_init                    memory init done
//   finished_transaction             transfer done
//   src_balance[AMT_W]               balance of src_sel player
//   random_init, init_memory,        phase enables
//   load_memory
//   load_src, load_dst,              one-cycle capture strobes
//   load_amount, load_key
//   start_transaction                high throughout TRANSACTION
//   reset_others                     low for the single CLEANUP cycle
//   src_sel, dst_sel [PW]            captured player indices
//   amount [AMT_W]                   captured amount
//   reject, timeout                  one-cycle status pulses
//   busy                             high in every state except IDLE
//
// Every output is a flop. Level outputs are registered from the next state,
// so they line up exactly with the state register. Strobes and status
// pulses are registered from the deciding transition, so reject and timeout
// appear in the first CLEANUP cycle and load_* in the first cycle of the
// following capture state.
// ---------------------------------------------------------------------------
module txn_sequencer
    import txn_pkg::*;
#(
    parameter int NUM_PLAYERS    = 2,
    parameter int AMT_W          = 8,
    parameter int INIT_CYCLES    = 512,
    parameter int TIMEOUT_CYCLES = 4095
) (
    input  logic                           clock,
    input  logic                           resetn,
    input  logic                           load_signal,
    input  logic                           start_signal,
    input  logic [AMT_W-1:0]               data_in,
    input  logic                           finished_init,
    input  logic                           finished_transaction,
    input  logic [AMT_W-1:0]               src_balance,
    output logic                           random_init,
    output logic                           init_memory,
    output logic                           load_memory,
    output logic                           load_src,
    output logic                           load_dst,
    output logic                           load_amount,
    output logic                           load_key,
    output logic                           start_transaction,
    output logic                           reset_others,
    output logic [$clog2(NUM_PLAYERS)-1:0] src_sel,
    output logic [$clog2(NUM_PLAYERS)-1:0] dst_sel,
    output logic [AMT_W-1:0]               amount,
    output logic                           reject,
    output logic                           timeout,
    output logic                           busy
);

    localparam int          PW      = $clog2(NUM_PLAYERS);
    localparam int          INIT_W  = cnt_width(INIT_CYCLES);
    localparam int          TO_W    = cnt_width(TIMEOUT_CYCLES);
    localparam logic [31:0] INIT_LIM = INIT_CYCLES;
    localparam logic [31:0] TO_LIM   = TIMEOUT_CYCLES;
    localparam logic [31:0] NP_LIM   = NUM_PLAYERS;

    // ---------------------------------------------------------------- state
    state_e              r_state;
    state_e              w_next_state;

    logic [INIT_W-1:0]   r_init_cnt;
    logic [TO_W-1:0]     r_to_cnt;

    logic [PW-1:0]       r_src_sel;
    logic [PW-1:0]       r_dst_sel;
    logic [AMT_W-1:0]    r_amount;

    logic                r_random_init;
    logic                r_init_memory;
    logic                r_load_memory;
    logic                r_start_transaction;
    logic                r_reset_others;
    logic                r_busy;
    logic                r_load_src;
    logic                r_load_dst;
    logic                r_load_amount;
    logic                r_load_key;
    logic                r_reject;
    logic                r_timeout;

    // -------------------------------------------------------- decode wires
    logic                w_load_evt;
    logic                w_init_last;
    logic                w_to_last;
    reject_cause_e       w_reject_cause;
    logic                w_reject;

    logic                w_cap_src;
    logic                w_cap_dst;
    logic                w_cap_amt;
    logic                w_cap_key;
    logic                w_reject_p;
    logic                w_timeout_p;
    logic                w_init_clr;
    logic                w_init_inc;
    logic                w_to_clr;
    logic                w_to_inc;

    edge_detect u_load_edge (
        .clk    (clock),
        .rst_n  (resetn),
        .i_sig  (load_signal),
        .o_rise (w_load_evt)
    );

    // Counters are compared in 32 bits so a limit of 0 or a full-width
    // limit cannot wrap the comparison.
    assign w_init_last = ((32'(r_init_cnt) + 32'd1) >= INIT_LIM);
    assign w_to_last   = (TO_LIM != 32'd0) && ((32'(r_to_cnt) + 32'd1) >= TO_LIM);

    // Legality of the captured transfer; indices outside the player range
    // were stored unchanged and are refused here.
    always_comb begin
        w_reject_cause = RC_NONE;
        if ((32'(r_src_sel) >= NP_LIM) || (32'(r_dst_sel) >= NP_LIM)) begin
            w_reject_cause = RC_BAD_IDX;
        end else if (r_src_sel == r_dst_sel) begin
            w_reject_cause = RC_SAME_IDX;
        end else if (r_amount == '0) begin
            w_reject_cause = RC_ZERO_AMT;
        end else if (r_amount > src_balance) begin
            w_reject_cause = RC_OVERDRAW;
        end
    end

    assign w_reject = (w_reject_cause != RC_NONE);

    // ------------------------------------------------------- state register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= INIT1;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------------------------------------- next state and controls
    // NOTE: every signal driven here gets a default first; a path that left
    // one unassigned would infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_cap_src    = 1'b0;
        w_cap_dst    = 1'b0;
        w_cap_amt    = 1'b0;
        w_cap_key    = 1'b0;
        w_reject_p   = 1'b0;
        w_timeout_p  = 1'b0;
        w_init_clr   = 1'b0;
        w_init_inc   = 1'b0;
        w_to_clr     = 1'b0;
        w_to_inc     = 1'b0;

        unique case (r_state)
            INIT1: begin
                if (w_init_last) begin
                    w_next_state = INIT2;
                end else begin
                    w_init_inc = 1'b1;
                end
            end
            INIT2: begin
                if (finished_init) begin
                    w_next_state = IDLE;
                end
            end
            // GET_SRC behaves as IDLE: waiting for the source capture.
            IDLE, GET_SRC: begin
                if (w_load_evt) begin
                    w_cap_src    = 1'b1;
                    w_next_state = GET_DST;
                end
            end
            GET_DST: begin
                if (w_load_evt) begin
                    w_cap_dst    = 1'b1;
                    w_next_state = GET_AMT;
                end
            end
            GET_AMT: begin
                if (w_load_evt) begin
                    w_cap_amt    = 1'b1;
                    w_next_state = GET_KEY;
                end
            end
            GET_KEY: begin
                if (w_load_evt) begin
                    w_cap_key    = 1'b1;
                    w_next_state = ARMED;
                end
            end
            ARMED: begin
                if (start_signal) begin
                    w_next_state = CHECK;
                end
            end
            CHECK: begin
                if (w_reject) begin
                    w_reject_p   = 1'b1;
                    w_next_state = CLEANUP;
                end else begin
                    w_to_clr     = 1'b1;
                    w_next_state = TRANSACTION;
                end
            end
            TRANSACTION: begin
                // A completion in the watchdog's last cycle takes priority.
                if (finished_transaction) begin
                    w_next_state = CLEANUP;
                end else if (w_to_last) begin
                    w_timeout_p  = 1'b1;
                    w_next_state = CLEANUP;
                end else begin
                    w_to_inc = 1'b1;
                end
            end
            CLEANUP: begin
                w_next_state = IDLE;
            end
            default: begin
                w_init_clr   = 1'b1;
                w_next_state = INIT1;
            end
        endcase
    end

    // ------------------------------------------------------------ counters
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_init_cnt <= '0;
            r_to_cnt   <= '0;
        end else begin
            if (w_init_clr) begin
                r_init_cnt <= '0;
            end else if (w_init_inc) begin
                r_init_cnt <= r_init_cnt + INIT_W'(1);
            end

            if (w_to_clr) begin
                r_to_cnt <= '0;
            end else if (w_to_inc) begin
                r_to_cnt <= r_to_cnt + TO_W'(1);
            end
        end
    end

    // ------------------------------------------------------ captured fields
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_src_sel <= '0;
            r_dst_sel <= '0;
            r_amount  <= '0;
        end else if (r_state == CLEANUP) begin
            r_src_sel <= '0;
            r_dst_sel <= '0;
            r_amount  <= '0;
        end else begin
            if (w_cap_src) begin
                r_src_sel <= data_in[PW-1:0];
            end
            if (w_cap_dst) begin
                r_dst_sel <= data_in[PW-1:0];
            end
            if (w_cap_amt) begin
                r_amount <= data_in;
            end
        end
    end

    // ---------------------------------------------------- registered outputs
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_random_init       <= 1'b1;
            r_init_memory       <= 1'b0;
            r_load_memory       <= 1'b0;
            r_start_transaction <= 1'b0;
            r_reset_others      <= 1'b1;
            r_busy              <= 1'b0;
            r_load_src          <= 1'b0;
            r_load_dst          <= 1'b0;
            r_load_amount       <= 1'b0;
            r_load_key          <= 1'b0;
            r_reject            <= 1'b0;
            r_timeout           <= 1'b0;
        end else begin
            r_random_init       <= (w_next_state == INIT1);
            r_init_memory       <= (w_next_state == INIT2);
            r_load_memory       <= (w_next_state == IDLE);
            r_start_transaction <= (w_next_state == TRANSACTION);
            r_reset_others      <= (w_next_state != CLEANUP);
            r_busy              <= (w_next_state != IDLE);
            r_load_src          <= w_cap_src;
            r_load_dst          <= w_cap_dst;
            r_load_amount       <= w_cap_amt;
            r_load_key          <= w_cap_key;
            r_reject            <= w_reject_p;
            r_timeout           <= w_timeout_p;
        end
    end

    assign random_init       = r_random_init;
    assign init_memory       = r_init_memory;
    assign load_memory       = r_load_memory;
    assign start_transaction = r_start_transaction;
    assign reset_others      = r_reset_others;
    assign busy              = r_busy;
    assign load_src          = r_load_src;
    assign load_dst          = r_load_dst;
    assign load_amount       = r_load_amount;
    assign load_key          = r_load_key;
    assign reject            = r_reject;
    assign timeout           = r_timeout;
    assign src_sel           = r_src_sel;
    assign dst_sel           = r_dst_sel;
    assign amount            = r_amount;

endmodule

// File: tb/tb_txn_sequencer.sv
// ---------------------------------------------------------------------------
// tb_txn_sequencer
// Self-checking bench for txn_sequencer (NUM_PLAYERS=3, AMT_W=8,
// INIT_CYCLES=512, TIMEOUT_CYCLES=8). Each transaction pushes its expected
// outcome into a scoreboard queue; a monitor pops and compares it when the
// DUT enters CLEANUP. Inputs are driven and outputs sampled on the falling
// clock edge.
// ---------------------------------------------------------------------------
module tb_txn_sequencer;

    localparam int NP    = 3;
    localparam int AW    = 8;
    localparam int PW    = 2;
    localparam int K_OK  = 0;
    localparam int K_REJ = 1;
    localparam int K_TO  = 2;

    localparam logic [11:0] VEC_RESET = 12'b1000_0000_1000;
    localparam logic [11:0] VEC_IDLE  = 12'b0010_0000_1000;

    typedef struct {
        logic [PW-1:0] src;
        logic [PW-1:0] dst;
        logic [AW-1:0] amt;
        int            kind;
        int            tx;
    } exp_t;

    logic          clock;
    logic          resetn;
    logic          load_signal;
    logic          start_signal;
    logic [AW-1:0] data_in;
    logic          finished_init;
    logic          finished_transaction;
    logic [AW-1:0] src_balance;
    logic          random_init, init_memory, load_memory;
    logic          load_src, load_dst, load_amount, load_key;
    logic          start_transaction, reset_others;
    logic [PW-1:0] src_sel, dst_sel;
    logic [AW-1:0] amount;
    logic          reject, timeout, busy;

    int   n_cmp;
    int   n_err;
    exp_t sb_q[$];

    txn_sequencer #(
        .NUM_PLAYERS    (NP),
        .AMT_W          (AW),
        .INIT_CYCLES    (512),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clock                (clock),
        .resetn               (resetn),
        .load_signal          (load_signal),
        .start_signal         (start_signal),
        .data_in              (data_in),
        .finished_init        (finished_init),
        .finished_transaction (finished_transaction),
        .src_balance          (src_balance),
        .random_init          (random_init),
        .init_memory          (init_memory),
        .load_memory          (load_memory),
        .load_src             (load_src),
        .load_dst             (load_dst),
        .load_amount          (load_amount),
        .load_key             (load_key),
        .start_transaction    (start_transaction),
        .reset_others         (reset_others),
        .src_sel              (src_sel),
        .dst_sel              (dst_sel),
        .amount               (amount),
        .reject               (reject),
        .timeout              (timeout),
        .busy                 (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    function automatic logic [11:0] out_vec();
        return {random_init, init_memory, load_memory, load_src, load_dst,
                load_amount, load_key, start_transaction, reset_others,
                reject, timeout, busy};
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------- monitor
    logic [PW-1:0] m_src, m_dst;
    logic [AW-1:0] m_amt;
    int            m_tx;
    int            m_strobes;

    initial begin
        m_src = '0; m_dst = '0; m_amt = '0; m_tx = 0; m_strobes = 0;
    end

    always @(negedge clock) begin
        if (!resetn) begin
            m_tx      = 0;
            m_strobes = 0;
        end else begin
            if (load_src)    m_src = src_sel;
            if (load_dst)    m_dst = dst_sel;
            if (load_amount) m_amt = amount;
            m_strobes += int'(load_src) + int'(load_dst) + int'(load_amount) + int'(load_key);
            if (start_transaction) m_tx++;
            if (!reset_others) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_outcome", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    int   kind;
                    e    = sb_q.pop_front();
                    kind = reject ? K_REJ : (timeout ? K_TO : K_OK);
                    check("sb_src",      32'(m_src), 32'(e.src));
                    check("sb_dst",      32'(m_dst), 32'(e.dst));
                    check("sb_amt",      32'(m_amt), 32'(e.amt));
                    check("sb_outcome",  kind,       e.kind);
                    check("sb_tx_cycles", m_tx,      e.tx);
                    check("sb_strobes",  m_strobes,  32'd4);
                end
                m_tx      = 0;
                m_strobes = 0;
            end
        end
    end

    // ------------------------------------------------------------ stimulus
    task automatic pulse_load(input logic [AW-1:0] val, input int hold,
                              output int n_strobe);
        n_strobe = 0;
        @(negedge clock);
        data_in     = val;
        load_signal = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clock);
            n_strobe += int'(load_src) + int'(load_dst) + int'(load_amount) + int'(load_key);
        end
        load_signal = 1'b0;
        @(negedge clock);
        n_strobe += int'(load_src) + int'(load_dst) + int'(load_amount) + int'(load_key);
    endtask

    task automatic drive_setup(input int src, input int dst, input int amt,
                               input int hold);
        int n;
        pulse_load(AW'(src), hold, n);
        check("load_src_single", n, 32'd1);
        pulse_load(AW'(dst), 1, n);
        pulse_load(AW'(amt), 1, n);
        pulse_load(8'hA5, 1, n);
        pulse_load(8'h00, 1, n);
        check("armed_load_ignored", n, 32'd0);
        @(negedge clock);
        start_signal = 1'b1;
    endtask

    task automatic run_txn(input int src, input int dst, input int amt,
                           input int hold, input int fin_after,
                           input int kind, input int tx);
        exp_t e;
        int   k;
        bit   seen;
        logic [31:0] v_src, v_dst, v_amt;
        v_src = src; v_dst = dst; v_amt = amt;
        e.src  = v_src[PW-1:0];
        e.dst  = v_dst[PW-1:0];
        e.amt  = v_amt[AW-1:0];
        e.kind = kind;
        e.tx   = tx;
        sb_q.push_back(e);

        drive_setup(src, dst, amt, hold);
        k    = 0;
        seen = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clock);
            start_signal = 1'b0;
            if (!reset_others) begin
                seen = 1'b1;
                break;
            end
            if (start_transaction) begin
                k++;
                if (k == fin_after) finished_transaction = 1'b1;
            end
        end
        finished_transaction = 1'b0;
        check("cleanup_reached", 32'(seen), 32'd1);

        @(negedge clock);
        check("idle_outputs", 32'(out_vec()), 32'(VEC_IDLE));
        check("idle_fields",  {8'd0, src_sel, dst_sel, amount}, 32'd0);
    endtask

    initial begin
        int cnt;
        n_cmp = 0;
        n_err = 0;
        resetn               = 1'b0;
        load_signal          = 1'b0;
        start_signal         = 1'b0;
        data_in              = '0;
        finished_init        = 1'b1;
        finished_transaction = 1'b0;
        src_balance          = 8'd50;

        repeat (3) @(negedge clock);
        check("reset_outputs", 32'(out_vec()), 32'(VEC_RESET));
        check("reset_fields",  {8'd0, src_sel, dst_sel, amount}, 32'd0);

        // Warm-up and memory-init phase lengths.
        resetn = 1'b1;
        cnt    = 0;
        for (int i = 0; i < 2000; i++) begin
            if (!random_init) break;
            cnt++;
            @(negedge clock);
        end
        check("random_init_cycles", cnt, 32'd512);
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            if (!init_memory) break;
            cnt++;
            @(negedge clock);
        end
        check("init_memory_cycles", cnt, 32'd1);
        check("idle_after_init", 32'(out_vec()), 32'(VEC_IDLE));

        // src, dst, amt, hold, finish-after, outcome, transaction cycles
        run_txn(0, 1, 20, 1,   3, K_OK,  3);   // normal transfer
        run_txn(0, 1, 60, 1,   0, K_REJ, 0);   // overdraw
        run_txn(1, 1, 10, 1,   0, K_REJ, 0);   // same player
        run_txn(3, 1, 10, 1,   0, K_REJ, 0);   // index out of range
        run_txn(2, 0,  0, 1,   0, K_REJ, 0);   // zero amount
        run_txn(0, 2, 50, 1,   2, K_OK,  2);   // amount equal to balance
        run_txn(1, 0,  5, 1,   0, K_TO,  8);   // watchdog expiry
        run_txn(1, 2,  5, 1,   8, K_OK,  8);   // finish on last watchdog cycle
        run_txn(2, 1,  7, 100, 1, K_OK,  1);   // held load button

        // Reset in the middle of a transfer.
        drive_setup(0, 1, 20, 1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            start_signal = 1'b0;
            if (start_transaction) break;
        end
        check("abort_txn_started", 32'(start_transaction), 32'd1);
        repeat (2) @(negedge clock);
        resetn = 1'b0;
        #1;
        check("abort_outputs", 32'(out_vec()), 32'(VEC_RESET));
        check("abort_fields",  {8'd0, src_sel, dst_sel, amount}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("abort_no_status", {30'd0, reject, timeout}, 32'd0);
        end
        resetn = 1'b1;
        @(negedge clock);
        check("abort_back_in_init1", 32'(random_init), 32'd1);
        check("sb_drained", sb_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/txn_sequencer.md
TXN_SEQUENCER -- requirements
Module: txn_sequencer

Interface
REQ-001 SHALL have parameter NUM_PLAYERS, default 2, number of player accounts (2..16).
REQ-002 SHALL have parameter AMT_W, default 8, width of amount and balance values.
REQ-003 SHALL have parameter INIT_CYCLES, default 512, cycles spent in random-seed warm-up.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 4095, transaction watchdog limit; 0 disables the watchdog.
REQ-005 SHALL use one clock; reset is asynchronous and active-low; the ports are clock and resetn.
REQ-006 Ports SHALL be as follows (PW = clog2(NUM_PLAYERS)):
  clock  in  1  system clock
  resetn  in  1  async active-low reset
  load_signal  in  1  active-high user load button
  start_signal  in  1  active-high user start button
  data_in  in  AMT_W  switch value captured on load
  finished_init  in  1  memory init done
  finished_transaction  in  1  animation/transfer done
  src_balance  in  AMT_W  balance read for src_sel
  random_init, init_memory, load_memory  out  1  phase enables
  load_src, load_dst, load_amount, load_key  out  1  one-cycle capture strobes
  start_transaction  out  1  level, high during TRANSACTION
  reset_others  out  1  active-low one-cycle datapath clear
  src_sel, dst_sel  out  PW  captured player indices
  amount  out  AMT_W  captured amount
  reject, timeout  out  1  one-cycle status pulses
  busy  out  1  high in every state except IDLE

Function
REQ-007 The state machine SHALL have these states: INIT1, INIT2, IDLE, GET_SRC, GET_DST, GET_AMT, GET_KEY, ARMED, CHECK, TRANSACTION, CLEANUP.
REQ-008 INIT1 SHALL assert random_init and count INIT_CYCLES cycles, then go to INIT2; the counter SHALL be cleared only by reset and on INIT1 entry.
REQ-009 INIT2 SHALL assert init_memory until finished_init=1, then go to IDLE.
REQ-010 IDLE SHALL assert load_memory.
REQ-011 A load event SHALL be a registered rising edge of load_signal (1 this cycle, 0 the previous cycle); holding load_signal high SHALL produce no further events.
REQ-012 From IDLE, a load event SHALL capture data_in[PW-1:0] into src_sel, pulse load_src, and move to GET_DST.
REQ-013 From GET_DST, a load event SHALL capture dst_sel and pulse load_dst; GET_AMT SHALL capture amount and pulse load_amount; GET_KEY SHALL pulse load_key only, then move to ARMED. GET_SRC SHALL be an alias entry state equal to IDLE-after-capture.
REQ-014 Captured indices >= NUM_PLAYERS SHALL be stored unchanged and rejected in CHECK.
REQ-015 ARMED SHALL wait for start_signal=1, then go to CHECK; further load events in ARMED SHALL be ignored.
REQ-016 CHECK SHALL last exactly one cycle. It SHALL reject when src_sel==dst_sel, amount==0, either index >= NUM_PLAYERS, or amount > src_balance (unsigned compare). On reject it SHALL pulse reject and go to CLEANUP; otherwise it SHALL go to TRANSACTION.
REQ-017 TRANSACTION SHALL hold start_transaction=1 until finished_transaction=1, then go to CLEANUP.
REQ-018 When TIMEOUT_CYCLES>0 and TRANSACTION has lasted TIMEOUT_CYCLES cycles without finished_transaction, the block SHALL pulse timeout and go to CLEANUP. If finished_transaction arrives in the same cycle, finished SHALL win and no timeout pulse SHALL be issued.
REQ-019 CLEANUP SHALL drive reset_others=0 for exactly one cycle, clear src_sel, dst_sel and amount, then go to IDLE.
REQ-020 reset_others SHALL be 1 in every state except CLEANUP.
REQ-021 All strobes SHALL be registered, glitch-free and one cycle wide.

Reset
REQ-022 resetn=0 SHALL asynchronously force state INIT1, clear both counters, clear src_sel, dst_sel and amount, and clear the edge-detect register.
REQ-023 During reset, all outputs SHALL be 0 except reset_others=1 and random_init=1.
REQ-024 Reset asserted in any state, including mid-TRANSACTION, SHALL abort the transaction with no reject or timeout pulse.

Structure
REQ-025 State encodings and the reject-cause constants SHALL live in a shared package, txn_pkg.
REQ-026 The load rising-edge detector SHALL be a sub-module, edge_detect, reusable for start_signal.

Verification
REQ-027 Reset, then hold finished_init=1 -> random_init high for exactly 512 cycles, init_memory high for 1 cycle, then IDLE with load_memory=1.
REQ-028 Four load pulses with data_in=0,1,20,x; src_balance=50; start -> src_sel=0, dst_sel=1, amount=20, start_transaction high until finished_transaction, then one reset_others low cycle.
REQ-029 Same sequence with amount=60 against src_balance=50 -> one reject pulse, start_transaction never asserted, fields cleared.
REQ-030 src_sel=dst_sel=1 -> reject; with NUM_PLAYERS=3, src_sel=3 -> reject.
REQ-031 TIMEOUT_CYCLES=8 and finished_transaction never asserted -> timeout pulse on the 8th TRANSACTION cycle, followed by CLEANUP; repeat with finished_transaction arriving on the 8th cycle -> no timeout pulse.
REQ-032 load_signal held high for 100 cycles -> exactly one load_src pulse; resetn dropped mid-TRANSACTION -> INIT1 immediately, with no status pulses.
